// File: rtl/icache_pkg.sv
// icache_pkg: shared types and helpers for the direct-mapped instruction
// cache controller.
//   - Address split: tag[31:12] / index[11:4] / word[3:2], byte bits ignored.
//   - icache_state_e: controller FSM states.
//   - addr_tag / addr_idx / addr_word: field extraction from a byte address.
package icache_pkg;

  localparam int ADDR_W      = 32;
  localparam int TAG_W       = 20;
  localparam int IDX_W       = 8;
  localparam int WORD_W      = 2;
  localparam int LINE_ADDR_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_LOOKUP      = 3'd1,
    ST_REFILL_REQ  = 3'd2,
    ST_REFILL_DATA = 3'd3,
    ST_REFILL_DONE = 3'd4
  } icache_state_e;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[31:12];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    return a[11:4];
  endfunction

  function automatic logic [WORD_W-1:0] addr_word(input logic [ADDR_W-1:0] a);
    return a[3:2];
  endfunction

endpackage

// File: rtl/icache_valid_array.sv
// icache_valid_array: one valid flop per cache line.
//   clk_i, rst_ni : clock, asynchronous active-low reset (clears all lines)
//   i_clr         : clear every valid bit in one cycle (wins over i_wr)
//   i_wr          : write i_wr_val into the bit selected by i_idx
//   i_idx         : line index for both the write and the read
//   o_valid       : combinational valid bit of line i_idx
module icache_valid_array
  import icache_pkg::*;
#(
  parameter int LINES = 256
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             i_clr,
  input  logic             i_wr,
  input  logic [IDX_W-1:0] i_idx,
  input  logic             i_wr_val,
  output logic             o_valid
);

  logic [LINES-1:0] r_valid;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= '0;
    end else if (i_clr) begin
      r_valid <= '0;
    end else if (i_wr) begin
      r_valid[i_idx] <= i_wr_val;
    end
  end

  assign o_valid = r_valid[i_idx];

endmodule

// File: rtl/icache_ctrl.sv
// icache_ctrl: lookup and refill controller for a direct-mapped icache
// (LINES lines x BEATS 32-bit words) sitting beside synchronous tag/data RAMs
// with 1-cycle read latency.
//   clk_i, rst_ni, flush_i            : clock, async active-low reset, flush all
//   req_valid_i/req_addr_i/req_ready_o: fetch request handshake
//   resp_valid_o/resp_data_o/resp_err_o: one-cycle response strobe
//   tag_addr_o/tag_wdata_o/tag_wr_o/tag_rdata_i     : tag RAM port
//   data_addr_o/data_wdata_o/data_wr_o/data_rdata_i : data RAM port
//   mem_req_o/mem_addr_o/mem_ack_i    : line refill request
//   mem_valid_i/mem_data_i/mem_err_i  : refill beats, word 0 first
module icache_ctrl
  import icache_pkg::*;
#(
  parameter int LINES = 256,
  parameter int BEATS = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   req_valid_i,
  input  logic [ADDR_W-1:0]      req_addr_i,
  output logic                   req_ready_o,
  output logic                   resp_valid_o,
  output logic [31:0]            resp_data_o,
  output logic                   resp_err_o,
  output logic [IDX_W-1:0]       tag_addr_o,
  output logic [TAG_W-1:0]       tag_wdata_o,
  output logic                   tag_wr_o,
  input  logic [TAG_W-1:0]       tag_rdata_i,
  output logic [LINE_ADDR_W-1:0] data_addr_o,
  output logic [31:0]            data_wdata_o,
  output logic                   data_wr_o,
  input  logic [31:0]            data_rdata_i,
  output logic                   mem_req_o,
  output logic [ADDR_W-1:0]      mem_addr_o,
  input  logic                   mem_ack_i,
  input  logic                   mem_valid_i,
  input  logic [31:0]            mem_data_i,
  input  logic                   mem_err_i
);

  icache_state_e     r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [WORD_W-1:0] r_beat;
  logic              r_err;
  logic              r_flush_pend;
  logic              r_resp_valid;
  logic              r_resp_err;
  logic [31:0]       r_resp_data;

  logic              w_idle;
  logic              w_hs;
  logic              w_flush_now;
  logic              w_line_valid;
  logic              w_hit;
  logic              w_beat_wr;
  logic              w_last_beat;
  logic              w_done;
  logic [IDX_W-1:0]  w_r_idx;
  logic              w_unused;

  assign w_idle      = (r_state == ST_IDLE);
  assign req_ready_o = w_idle && !flush_i && !r_flush_pend;
  assign w_hs        = req_valid_i && req_ready_o;
  // A flush raised while busy is parked and applied on the first idle cycle,
  // so a line refilled in the meantime still ends up invalid.
  assign w_flush_now = w_idle && (flush_i || r_flush_pend);
  assign w_r_idx     = addr_idx(r_addr);
  assign w_hit       = w_line_valid && (tag_rdata_i == addr_tag(r_addr));
  assign w_beat_wr   = (r_state == ST_REFILL_DATA) && mem_valid_i;
  assign w_last_beat = w_beat_wr && (r_beat == WORD_W'(BEATS - 1));
  assign w_done      = (r_state == ST_REFILL_DONE);
  assign w_unused    = ^r_addr[1:0];

  // RAM addresses come straight from the request while idle so the read
  // data lines up with the LOOKUP cycle; afterwards they follow the
  // latched address and the refill beat counter.
  assign tag_addr_o   = w_idle ? addr_idx(req_addr_i) : w_r_idx;
  assign data_addr_o  = w_idle ? {addr_idx(req_addr_i), addr_word(req_addr_i)}
                               : {w_r_idx, r_beat};
  assign tag_wr_o     = w_done;
  assign tag_wdata_o  = addr_tag(r_addr);
  assign data_wr_o    = w_beat_wr;
  assign data_wdata_o = w_beat_wr ? mem_data_i : '0;
  assign mem_req_o    = (r_state == ST_REFILL_REQ);
  assign mem_addr_o   = {r_addr[ADDR_W-1:4], 4'b0000};

  assign resp_valid_o = r_resp_valid;
  assign resp_data_o  = r_resp_data;
  assign resp_err_o   = r_resp_err;

  // The error outcome is written as the valid bit, so an errored refill
  // also invalidates whatever line previously lived at this index (its tag
  // has just been overwritten).
  icache_valid_array #(
    .LINES (LINES)
  ) u_valid (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .i_clr    (w_flush_now),
    .i_wr     (w_done),
    .i_idx    (w_r_idx),
    .i_wr_val (!r_err),
    .o_valid  (w_line_valid)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_beat       <= '0;
      r_err        <= 1'b0;
      r_flush_pend <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_data  <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      if (w_idle) begin
        r_flush_pend <= 1'b0;
      end else if (flush_i) begin
        r_flush_pend <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_hs) begin
            r_addr  <= req_addr_i;
            r_state <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (w_hit) begin
            r_resp_data  <= data_rdata_i;
            r_resp_valid <= 1'b1;
            r_state      <= ST_IDLE;
          end else begin
            r_state <= ST_REFILL_REQ;
          end
        end
        ST_REFILL_REQ: begin
          if (mem_ack_i) begin
            r_beat  <= '0;
            r_state <= ST_REFILL_DATA;
          end
        end
        ST_REFILL_DATA: begin
          if (mem_valid_i) begin
            if (r_beat == addr_word(r_addr)) begin
              r_resp_data <= mem_data_i;
            end
            r_err  <= r_err | mem_err_i;
            r_beat <= r_beat + 1'b1;
            if (w_last_beat) begin
              r_state <= ST_REFILL_DONE;
            end
          end
        end
        ST_REFILL_DONE: begin
          r_resp_valid <= 1'b1;
          r_resp_err   <= r_err;
          r_err        <= 1'b0;
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: self-checking bench for icache_ctrl. Models the two
// 1-cycle-latency RAMs and a backing memory, and predicts hit/miss, data and
// error outcome from a plain array model of the cache contents.
module tb_icache_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic        req_ready_o;
  logic        resp_valid_o;
  logic [31:0] resp_data_o;
  logic        resp_err_o;
  logic [7:0]  tag_addr_o;
  logic [19:0] tag_wdata_o;
  logic        tag_wr_o;
  logic [19:0] tag_rdata_i;
  logic [9:0]  data_addr_o;
  logic [31:0] data_wdata_o;
  logic        data_wr_o;
  logic [31:0] data_rdata_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i = 1'b0;
  logic        mem_valid_i = 1'b0;
  logic [31:0] mem_data_i = '0;
  logic        mem_err_i = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  // Reference view of the cache: which line holds which tag.
  bit          m_valid [256];
  logic [19:0] m_tag   [256];
  // Backing memory: explicit words where a test needs them, hash elsewhere.
  logic [31:0] ovr [int unsigned];

  logic [19:0] tag_ram  [256];
  logic [31:0] data_ram [1024];

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (tag_wr_o) tag_ram[tag_addr_o] <= tag_wdata_o;
    tag_rdata_i <= tag_ram[tag_addr_o];
    if (data_wr_o) data_ram[data_addr_o] <= data_wdata_o;
    data_rdata_i <= data_ram[data_addr_o];
  end

  icache_ctrl #(.LINES(256), .BEATS(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_ready_o(req_ready_o),
    .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o), .resp_err_o(resp_err_o),
    .tag_addr_o(tag_addr_o), .tag_wdata_o(tag_wdata_o), .tag_wr_o(tag_wr_o),
    .tag_rdata_i(tag_rdata_i),
    .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o), .data_wr_o(data_wr_o),
    .data_rdata_i(data_rdata_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i),
    .mem_valid_i(mem_valid_i), .mem_data_i(mem_data_i), .mem_err_i(mem_err_i)
  );

  function automatic logic [31:0] memval(input logic [31:0] wa);
    if (ovr.exists(wa)) return ovr[wa];
    return {wa[15:0] ^ 16'hC3A5, wa[31:16] ^ 16'h1F2E};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
  endtask

  // One complete fetch. Entered and left on a falling edge. err_beat /
  // flush_beat select a refill beat carrying an error or a concurrent flush
  // (-1 for none); fast=1 gives immediate ack and back-to-back beats.
  task automatic do_fetch(input logic [31:0] a, input bit fast,
                          input int err_beat, input int flush_beat);
    logic [19:0] t;
    logic [7:0]  ix;
    logic [1:0]  w;
    logic [31:0] line, exp_data, obs_data;
    bit exp_hit, exp_err, seen_req, acked, got_resp, seen_tagwr, obs_err, flushed;
    int beat, tagwr_cyc, resp_cyc;
    t = a[31:12]; ix = a[11:4]; w = a[3:2];
    line = {a[31:4], 4'h0};
    exp_data = memval({a[31:2], 2'b00});
    exp_hit = m_valid[ix] && (m_tag[ix] == t);
    exp_err = !exp_hit && (err_beat >= 0) && (err_beat < 4);
    seen_req = 0; acked = 0; got_resp = 0; seen_tagwr = 0; obs_err = 0; flushed = 0;
    obs_data = '0; beat = 0; tagwr_cyc = -1; resp_cyc = -1;

    n_checks++;
    if (req_ready_o !== 1'b1) begin
      n_errors++; $display("FAIL ready_idle addr=%h: got %b want 1", a, req_ready_o);
    end
    req_valid_i = 1'b1; req_addr_i = a;
    #1;
    n_checks++;
    if (tag_addr_o !== ix) begin
      n_errors++; $display("FAIL tag_addr_req: got %h want %h", tag_addr_o, ix);
    end
    n_checks++;
    if (data_addr_o !== {ix, w}) begin
      n_errors++; $display("FAIL data_addr_req: got %h want %h", data_addr_o, {ix, w});
    end
    @(negedge clk_i);
    req_valid_i = 1'b0; req_addr_i = $urandom;

    for (int cyc = 1; cyc <= 80 && !got_resp; cyc++) begin
      mem_ack_i = 1'b0; mem_valid_i = 1'b0; mem_err_i = 1'b0; flush_i = 1'b0;
      mem_data_i = $urandom;
      if (resp_valid_o) begin
        got_resp = 1; resp_cyc = cyc; obs_data = resp_data_o; obs_err = resp_err_o;
      end
      if (tag_wr_o) begin
        seen_tagwr = 1; tagwr_cyc = cyc;
        n_checks++;
        if (tag_addr_o !== ix || tag_wdata_o !== t) begin
          n_errors++;
          $display("FAIL tag_write: got idx=%h tag=%h want idx=%h tag=%h",
                   tag_addr_o, tag_wdata_o, ix, t);
        end
      end
      if (mem_req_o) begin
        seen_req = 1;
        n_checks++;
        if (mem_addr_o !== line) begin
          n_errors++; $display("FAIL mem_addr: got %h want %h", mem_addr_o, line);
        end
        if (fast || $urandom_range(0, 2) == 0) begin
          mem_ack_i = 1'b1; acked = 1;
        end else if ($urandom_range(0, 1) == 1) begin
          mem_valid_i = 1'b1;  // stray beat before the ack, must be ignored
        end
      end else if (acked && beat < 4) begin
        if (beat == flush_beat && !flushed) begin
          flush_i = 1'b1; flushed = 1;
        end
        if (fast || $urandom_range(0, 3) != 0) begin
          mem_valid_i = 1'b1;
          mem_data_i = memval(line + 32'(beat * 4));
          mem_err_i = (beat == err_beat);
          #1;
          n_checks++;
          if (data_wr_o !== 1'b1 || data_addr_o !== {ix, 2'(beat)} || data_wdata_o !== mem_data_i) begin
            n_errors++;
            $display("FAIL beat_write b=%0d: got wr=%b a=%h d=%h want wr=1 a=%h d=%h",
                     beat, data_wr_o, data_addr_o, data_wdata_o, {ix, 2'(beat)}, mem_data_i);
          end
          beat++;
        end else begin
          #1;
          n_checks++;
          if (data_wr_o !== 1'b0) begin
            n_errors++; $display("FAIL gap_write: got %b want 0", data_wr_o);
          end
        end
      end
      if (!got_resp) @(negedge clk_i);
    end

    n_checks++;
    if (!got_resp) begin
      n_errors++; $display("FAIL resp_timeout addr=%h: got none want resp", a);
    end
    n_checks++;
    if (seen_req !== !exp_hit) begin
      n_errors++; $display("FAIL hit_miss addr=%h: got refill=%b want %b", a, seen_req, !exp_hit);
    end
    if (exp_hit) begin
      n_checks++;
      if (resp_cyc != 2) begin
        n_errors++; $display("FAIL hit_latency addr=%h: got %0d want 2", a, resp_cyc);
      end
    end else begin
      n_checks++;
      if (!seen_tagwr || resp_cyc != tagwr_cyc + 1) begin
        n_errors++;
        $display("FAIL miss_resp_timing addr=%h: got resp=%0d tagwr=%0d want resp=tagwr+1",
                 a, resp_cyc, tagwr_cyc);
      end
    end
    n_checks++;
    if (obs_err !== exp_err) begin
      n_errors++; $display("FAIL resp_err addr=%h: got %b want %b", a, obs_err, exp_err);
    end
    if (!exp_err) begin
      n_checks++;
      if (obs_data !== exp_data) begin
        n_errors++; $display("FAIL resp_data addr=%h: got %h want %h", a, obs_data, exp_data);
      end
    end

    if (!exp_hit) begin
      m_tag[ix] = t;
      m_valid[ix] = !exp_err;
    end
    if (flushed) begin
      model_clear();
      n_checks++;
      if (req_ready_o !== 1'b0) begin
        n_errors++; $display("FAIL ready_flush_pend: got %b want 0", req_ready_o);
      end
      @(negedge clk_i);
    end
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (req_ready_o !== 1'b1) begin n_errors++; $display("FAIL rst_ready: got %b want 1", req_ready_o); end
    n_checks++; if (resp_valid_o !== 1'b0) begin n_errors++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid_o); end
    n_checks++; if (resp_data_o !== 32'h0) begin n_errors++; $display("FAIL rst_resp_data: got %h want 0", resp_data_o); end
    n_checks++; if (resp_err_o !== 1'b0) begin n_errors++; $display("FAIL rst_resp_err: got %b want 0", resp_err_o); end
    n_checks++; if (tag_wr_o !== 1'b0) begin n_errors++; $display("FAIL rst_tag_wr: got %b want 0", tag_wr_o); end
    n_checks++; if (tag_wdata_o !== 20'h0) begin n_errors++; $display("FAIL rst_tag_wdata: got %h want 0", tag_wdata_o); end
    n_checks++; if (data_wr_o !== 1'b0) begin n_errors++; $display("FAIL rst_data_wr: got %b want 0", data_wr_o); end
    n_checks++; if (data_wdata_o !== 32'h0) begin n_errors++; $display("FAIL rst_data_wdata: got %h want 0", data_wdata_o); end
    n_checks++; if (mem_req_o !== 1'b0) begin n_errors++; $display("FAIL rst_mem_req: got %b want 0", mem_req_o); end
    n_checks++; if (mem_addr_o !== 32'h0) begin n_errors++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr_o); end
    rst_ni = 1'b1;
    @(negedge clk_i);
    n_checks++; if (resp_valid_o !== 1'b0) begin n_errors++; $display("FAIL post_rst_resp: got %b want 0", resp_valid_o); end
  endtask

  task automatic test_cold_miss();
    do_fetch(32'h0000_1004, 1'b1, -1, -1);
  endtask

  task automatic test_hit();
    do_fetch(32'h0000_100C, 1'b1, -1, -1);
  endtask

  task automatic test_back_to_back();
    do_fetch(32'h0000_1000, 1'b1, -1, -1);
    do_fetch(32'h0000_1008, 1'b1, -1, -1);
    do_fetch(32'h0000_1005, 1'b1, -1, -1);
  endtask

  task automatic test_conflict();
    do_fetch(32'h0000_2004, 1'b1, -1, -1);
    do_fetch(32'h0000_1004, 1'b1, -1, -1);
  endtask

  task automatic test_flush();
    do_fetch(32'h0000_1004, 1'b1, -1, -1);
    flush_i = 1'b1; req_valid_i = 1'b1; req_addr_i = 32'h0000_1004;
    #1;
    n_checks++;
    if (req_ready_o !== 1'b0) begin
      n_errors++; $display("FAIL flush_ready: got %b want 0", req_ready_o);
    end
    @(negedge clk_i);
    flush_i = 1'b0; req_valid_i = 1'b0;
    model_clear();
    @(negedge clk_i);
    n_checks++;
    if (resp_valid_o !== 1'b0) begin
      n_errors++; $display("FAIL flush_no_resp: got %b want 0", resp_valid_o);
    end
    do_fetch(32'h0000_1004, 1'b1, -1, -1);
  endtask

  task automatic test_flush_during_refill();
    do_fetch(32'h0000_5008, 1'b1, -1, 1);
    do_fetch(32'h0000_5008, 1'b1, -1, -1);
  endtask

  task automatic test_error_beat();
    do_fetch(32'h0000_3000, 1'b1, 2, -1);
    do_fetch(32'h0000_3000, 1'b1, -1, -1);
  endtask

  task automatic test_reset_mid_refill();
    int k;
    req_valid_i = 1'b1; req_addr_i = 32'h0000_7010;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    k = 0;
    while (!mem_req_o && k < 10) begin @(negedge clk_i); k++; end
    n_checks++;
    if (mem_req_o !== 1'b1) begin
      n_errors++; $display("FAIL rstmid_req: got %b want 1", mem_req_o);
    end
    mem_ack_i = 1'b1;
    @(negedge clk_i);
    mem_ack_i = 1'b0; mem_valid_i = 1'b1; mem_data_i = 32'h1111_0000;
    @(negedge clk_i);
    mem_data_i = 32'h1111_0004;
    @(negedge clk_i);
    mem_valid_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    n_checks++; if (mem_req_o !== 1'b0) begin n_errors++; $display("FAIL rstmid_mem_req: got %b want 0", mem_req_o); end
    n_checks++; if (tag_wr_o !== 1'b0) begin n_errors++; $display("FAIL rstmid_tag_wr: got %b want 0", tag_wr_o); end
    n_checks++; if (req_ready_o !== 1'b1) begin n_errors++; $display("FAIL rstmid_ready: got %b want 1", req_ready_o); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      n_checks++;
      if (resp_valid_o !== 1'b0 || tag_wr_o !== 1'b0) begin
        n_errors++; $display("FAIL rstmid_quiet: got resp=%b tagwr=%b want 0 0", resp_valid_o, tag_wr_o);
      end
    end
    rst_ni = 1'b1;
    model_clear();
    @(negedge clk_i);
    do_fetch(32'h0000_7010, 1'b1, -1, -1);
  endtask

  task automatic test_random();
    logic [31:0] a;
    int eb, fb;
    for (int n = 0; n < 60; n++) begin
      a = {20'($urandom_range(1, 3)), 8'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3))};
      eb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
      fb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
      do_fetch(a, 1'b0, eb, fb);
    end
  endtask

  initial begin
    model_clear();
    for (int i = 0; i < 4; i++) ovr[32'h0000_1000 + 4 * i] = 32'h0000_00A0 + i;
    repeat (2) @(negedge clk_i);
    test_reset();
    test_cold_miss();
    test_hit();
    test_back_to_back();
    test_conflict();
    test_flush();
    test_flush_during_refill();
    test_error_beat();
    test_reset_mid_refill();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
